// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse macro emulator.
package efuse_pkg;

    localparam int EFUSE_AW = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM_PGM   = 3'd1,
        ST_ARM_RD    = 3'd2,
        ST_PGM_PULSE = 3'd3,
        ST_RD_PULSE  = 3'd4
    } efuse_emu_st_e;

    localparam int ERR_MODE  = 0;
    localparam int ERR_SETUP = 1;
    localparam int ERR_SHORT = 2;
    localparam int ERR_ABORT = 3;

endpackage

// File: rtl/efuse_emu_array.sv
// Fuse storage: bits can only be set (blown); reset reloads the factory image.
module efuse_emu_array
    import efuse_pkg::*;
#(
    parameter int                    NBYTE    = 32,
    parameter logic [8*NBYTE-1:0]    INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  logic [EFUSE_AW-1:0] set_idx_i,
    input  logic [EFUSE_AW-1:0] rd_addr_i,
    output logic [7:0]          rd_data_o
);

    localparam int NBIT = 8 * NBYTE;

    logic [NBIT-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= INIT_VAL;
        end else if (set_en_i && (int'(set_idx_i) < NBIT)) begin
            mem_q[set_idx_i] <= 1'b1;
        end
    end

    // Bytes past the array read as zero rather than aliasing.
    always_comb begin
        rd_data_o = '0;
        if (int'(rd_addr_i[EFUSE_AW-1:3]) < NBYTE) begin
            rd_data_o = mem_q[{rd_addr_i[EFUSE_AW-1:3], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/efuse_macro_emu.sv
// Behavioural eFuse hard-macro emulator: pin-protocol FSM, pulse timing,
// sticky protocol errors and program-pulse counting in front of the fuse array.
module efuse_macro_emu
    import efuse_pkg::*;
#(
    parameter int                 NBYTE    = 32,
    parameter int                 TPGM_MIN = 4,
    parameter int                 TRD_MIN  = 2,
    parameter logic [8*NBYTE-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                efuse_pgmen_i,
    input  logic                efuse_rden_i,
    input  logic                efuse_aen_i,
    input  logic [EFUSE_AW-1:0] efuse_addr_i,
    output logic [7:0]          efuse_rdata_o,
    output logic [3:0]          err_o,
    input  logic                err_clr_i,
    output logic [8:0]          pgm_cnt_o,
    output logic [2:0]          dbg_state_o
);

    efuse_emu_st_e       state_q;
    logic                aen_q;
    logic [7:0]          cnt_q;
    logic [EFUSE_AW-1:0] addr_cap_q;
    logic [7:0]          rdata_q;
    logic [3:0]          err_q;
    logic [8:0]          pgm_cnt_q;

    logic       both_mode;
    logic       in_pgm;
    logic       in_rd;
    logic       pgm_commit;
    logic       rd_done;
    logic       rd_ok;
    logic       bit_in_range;
    logic [3:0] err_set;
    logic [7:0] arr_rdata;

    always_comb begin
        both_mode    = efuse_pgmen_i & efuse_rden_i;
        in_pgm       = (state_q == ST_PGM_PULSE);
        in_rd        = (state_q == ST_RD_PULSE);
        bit_in_range = int'(addr_cap_q) < 8 * NBYTE;
        pgm_commit   = !both_mode && in_pgm && !efuse_aen_i && (int'(cnt_q) >= TPGM_MIN);
        rd_done      = !both_mode && in_rd && !efuse_aen_i;
        rd_ok        = rd_done && (int'(cnt_q) >= TRD_MIN);

        err_set            = '0;
        err_set[ERR_MODE]  = both_mode;
        err_set[ERR_SETUP] = (state_q == ST_IDLE) && efuse_aen_i && !aen_q;
        err_set[ERR_SHORT] = !both_mode && !efuse_aen_i &&
                             ((in_pgm && (int'(cnt_q) < TPGM_MIN)) ||
                              (in_rd  && (int'(cnt_q) < TRD_MIN)));
        // Any wobble of address or the owning mode pin while the strobe is high.
        err_set[ERR_ABORT] = !both_mode && efuse_aen_i &&
                             ((in_pgm && ((efuse_addr_i != addr_cap_q) || !efuse_pgmen_i)) ||
                              (in_rd  && ((efuse_addr_i != addr_cap_q) || !efuse_rden_i)));
    end

    efuse_emu_array #(
        .NBYTE    (NBYTE),
        .INIT_VAL (INIT_VAL)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (pgm_commit),
        .set_idx_i (addr_cap_q),
        .rd_addr_i (addr_cap_q),
        .rd_data_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            aen_q      <= 1'b0;
            cnt_q      <= '0;
            addr_cap_q <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
            pgm_cnt_q  <= '0;
        end else begin
            aen_q <= efuse_aen_i;
            err_q <= (err_clr_i ? 4'b0000 : err_q) | err_set;

            if (pgm_commit && bit_in_range && (pgm_cnt_q != 9'h1FF)) begin
                pgm_cnt_q <= pgm_cnt_q + 9'd1;
            end
            if (rd_done) begin
                rdata_q <= rd_ok ? arr_rdata : 8'h00;
            end

            if (both_mode) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // A strobe already high keeps us here until it drops.
                        if (!efuse_aen_i) begin
                            if (efuse_pgmen_i)     state_q <= ST_ARM_PGM;
                            else if (efuse_rden_i) state_q <= ST_ARM_RD;
                        end
                    end
                    ST_ARM_PGM: begin
                        if (!efuse_pgmen_i) begin
                            state_q <= ST_IDLE;
                        end else if (efuse_aen_i) begin
                            state_q    <= ST_PGM_PULSE;
                            cnt_q      <= 8'd1;
                            addr_cap_q <= efuse_addr_i;
                        end
                    end
                    ST_ARM_RD: begin
                        if (!efuse_rden_i) begin
                            state_q <= ST_IDLE;
                        end else if (efuse_aen_i) begin
                            state_q    <= ST_RD_PULSE;
                            cnt_q      <= 8'd1;
                            addr_cap_q <= efuse_addr_i;
                        end
                    end
                    ST_PGM_PULSE: begin
                        if (efuse_aen_i) begin
                            if (err_set[ERR_ABORT]) state_q <= ST_IDLE;
                            else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                        end else begin
                            state_q <= efuse_pgmen_i ? ST_ARM_PGM : ST_IDLE;
                        end
                    end
                    ST_RD_PULSE: begin
                        if (efuse_aen_i) begin
                            if (err_set[ERR_ABORT]) state_q <= ST_IDLE;
                            else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                        end else begin
                            state_q <= efuse_rden_i ? ST_ARM_RD : ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign efuse_rdata_o = rdata_q;
    assign err_o         = err_q;
    assign pgm_cnt_o     = pgm_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_efuse_macro_emu.sv
// Directed bench for the eFuse macro emulator: reads, programs, protocol errors, reset.
module tb_efuse_macro_emu;
    import efuse_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pgmen, rden, aen, err_clr;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic [3:0] err;
    logic [8:0] pgm_cnt;
    logic [2:0] dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    efuse_macro_emu dut (
        .clk           (clk),
        .rst           (rst),
        .efuse_pgmen_i (pgmen),
        .efuse_rden_i  (rden),
        .efuse_aen_i   (aen),
        .efuse_addr_i  (addr),
        .efuse_rdata_o (rdata),
        .err_o         (err),
        .err_clr_i     (err_clr),
        .pgm_cnt_o     (pgm_cnt),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic strobe(input logic [7:0] a, input int n);
        aen  = 1'b1;
        addr = a;
        repeat (n) tick();
        aen = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        rden = 1'b1;
        tick();
        strobe(a, n);
        rden = 1'b0;
        tick();
    endtask

    task automatic do_prog(input logic [7:0] a, input int n);
        pgmen = 1'b1;
        tick();
        strobe(a, n);
        pgmen = 1'b0;
        tick();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pgmen = 1'b0; rden = 1'b0; aen = 1'b0; err_clr = 1'b0; addr = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_rdata", 16'(rdata), 16'h00);
        check("rst_err", 16'(err), 16'h0);
        check("rst_pgm_cnt", 16'(pgm_cnt), 16'd0);
        check("rst_state", 16'(dbg_state), 16'(ST_IDLE));

        // Minimum-width read of byte 1 from the factory image.
        rden = 1'b1; tick();
        aen = 1'b1; addr = 8'h08; tick(); tick();
        aen = 1'b0; tick();
        check("rd_init_rdata", 16'(rdata), 16'h00);
        check("rd_init_err", 16'(err), 16'h0);
        check("rd_init_state", 16'(dbg_state), 16'(ST_ARM_RD));
        rden = 1'b0; tick();

        // Program bit 11 with a minimum-width pulse, then read it back.
        pgmen = 1'b1; tick();
        strobe(8'h0B, 4);
        check("pgm_cnt_1", 16'(pgm_cnt), 16'd1);
        check("pgm_state_rearm", 16'(dbg_state), 16'(ST_ARM_PGM));
        pgmen = 1'b0; tick();
        do_read(8'h08, 2);
        check("rd_bit3", 16'(rdata), 16'h08);
        check("pgm_err_none", 16'(err), 16'h0);

        // Short program pulse: nothing blown, short-pulse error.
        do_prog(8'h00, 3);
        check("short_pgm_err", 16'(err), 16'h4);
        check("short_pgm_cnt", 16'(pgm_cnt), 16'd1);
        do_read(8'h00, 2);
        check("short_pgm_rd", 16'(rdata), 16'h00);
        clear_err();
        check("err_clr", 16'(err), 16'h0);

        // Short read zeroes rdata.
        do_read(8'h08, 2);
        check("rd_again", 16'(rdata), 16'h08);
        do_read(8'h08, 1);
        check("short_rd_rdata", 16'(rdata), 16'h00);
        check("short_rd_err", 16'(err), 16'h4);
        clear_err();

        // Both modes high forces IDLE; a later bare strobe is a setup error.
        pgmen = 1'b1; rden = 1'b1; tick();
        check("both_err", 16'(err), 16'h1);
        check("both_state", 16'(dbg_state), 16'(ST_IDLE));
        pgmen = 1'b0; rden = 1'b0; tick();
        aen = 1'b1; addr = 8'h08; tick();
        check("bare_aen_err", 16'(err), 16'h3);
        check("bare_aen_state", 16'(dbg_state), 16'(ST_IDLE));
        aen = 1'b0; tick();
        check("bare_aen_cnt", 16'(pgm_cnt), 16'd1);
        clear_err();

        // Back-to-back program pulses with pgmen held.
        pgmen = 1'b1; tick();
        strobe(8'h20, 4);
        strobe(8'h21, 4);
        check("b2b_cnt", 16'(pgm_cnt), 16'd3);
        check("b2b_err", 16'(err), 16'h0);

        // Address change mid-pulse aborts without blowing.
        aen = 1'b1; addr = 8'h10; tick(); tick();
        addr = 8'h11; tick();
        check("abort_err", 16'(err), 16'h8);
        check("abort_state", 16'(dbg_state), 16'(ST_IDLE));
        aen = 1'b0; pgmen = 1'b0; tick();
        do_read(8'h20, 2);
        check("b2b_rd", 16'(rdata), 16'h03);
        do_read(8'h10, 2);
        check("abort_rd", 16'(rdata), 16'h00);
        check("abort_cnt", 16'(pgm_cnt), 16'd3);
        do_read(8'h08, 2);

        // Reset in the middle of a program pulse.
        pgmen = 1'b1; tick();
        aen = 1'b1; addr = 8'h30; tick(); tick();
        rst = 1'b1; tick();
        check("rst_mid_rdata", 16'(rdata), 16'h00);
        check("rst_mid_err", 16'(err), 16'h0);
        check("rst_mid_cnt", 16'(pgm_cnt), 16'd0);
        check("rst_mid_state", 16'(dbg_state), 16'(ST_IDLE));
        rst = 1'b0; aen = 1'b0; pgmen = 1'b0; tick();
        do_read(8'h08, 2);
        check("rst_reload", 16'(rdata), 16'h00);

        // Mode and strobe rising together: setup error, rdata held.
        do_prog(8'h0B, 4);
        do_read(8'h08, 2);
        check("reprog_rd", 16'(rdata), 16'h08);
        rden = 1'b1; aen = 1'b1; addr = 8'h00; tick();
        check("setup_err", 16'(err), 16'h2);
        check("setup_rdata", 16'(rdata), 16'h08);
        check("setup_state", 16'(dbg_state), 16'(ST_IDLE));
        tick(); tick();
        check("setup_hold_state", 16'(dbg_state), 16'(ST_IDLE));
        aen = 1'b0; tick();
        check("setup_rearm", 16'(dbg_state), 16'(ST_ARM_RD));
        check("setup_rdata_end", 16'(rdata), 16'h08);
        rden = 1'b0; tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/efuse_macro_emu.md
# efuse_macro_emu

Synthesizable behavioural emulator of the eFuse hard macro. It sits at the far end of the eFuse pin bus (pgmen/rden/aen/addr out, rdata back) and replaces the macro in FPGA prototypes and RTL simulation. It answers read pulses with array data and commits program pulses as irreversible bit blows. It checks the pin protocol and reports violations as sticky error flags.

## Interface
- NBYTE, 32: array depth in bytes (8*NBYTE fuse bits, addressable by 8-bit addr).
- TPGM_MIN, 4: minimum aen-high cycles for a program pulse to blow a bit.
- TRD_MIN, 2: minimum aen-high cycles for a read pulse to return data.
- INIT_VAL, '0: 8*NBYTE-bit array contents loaded on reset ("factory" state).

Ports:
- clk  in  1  clock; one clock domain, all inputs sampled on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- efuse_pgmen_i  in  1  program mode enable.
- efuse_rden_i  in  1  read mode enable.
- efuse_aen_i  in  1  access strobe; pulse width measured in clk cycles.
- efuse_addr_i  in  8  program: bit index [7:0]; read: byte index [7:3], [2:0] ignored.
- efuse_rdata_o  out  8  read data, registered.
- err_o  out  4  sticky protocol errors: [0] pgmen&rden both high, [1] setup violation, [2] short pulse, [3] abort (mode/addr change mid-pulse).
- err_clr_i  in  1  clears err_o next cycle; a new error in the same cycle wins.
- pgm_cnt_o  out  9  count of committed program pulses, saturating at 511.

## Operation
- States: IDLE, ARM_PGM, ARM_RD, PGM_PULSE, RD_PULSE.
- IDLE -> ARM_PGM on pgmen=1, rden=0, aen=0. IDLE -> ARM_RD on rden=1, pgmen=0, aen=0. ARM_* -> IDLE when the mode input drops.
- ARM_PGM/ARM_RD -> PGM_PULSE/RD_PULSE on aen rise. Capture addr and clear the width counter to 1 on the same edge.
- aen rise while in IDLE sets err[1]. The FSM stays in IDLE and the pulse is ignored until aen falls.
- In PULSE: counter increments each cycle aen=1 and saturates at 255. A change of addr or of the mode input while aen=1 sets err[3]. The FSM then goes to IDLE with no commit.
- aen fall in PGM_PULSE: if count >= TPGM_MIN, array bit addr_cap is set to 1 and pgm_cnt increments. Otherwise err[2] is set and nothing changes. Next state is ARM_PGM if pgmen is still 1, else IDLE.
- aen fall in RD_PULSE: if count >= TRD_MIN, efuse_rdata_o <= byte addr_cap[7:3]. Otherwise err[2] is set and rdata <= 8'h00. Next state is ARM_RD or IDLE, by the same rule.
- pgmen=1 and rden=1 in the same cycle, in any state, sets err[0] and forces IDLE.
- Blown bits never clear, except through rst. Re-blowing a bit that is already 1 still counts in pgm_cnt.
- Byte index >= NBYTE: a read returns 8'h00 and a program is dropped. Neither sets an error.

## Timing
- Reset values: efuse_rdata_o=0, err_o=0, pgm_cnt_o=0, state=IDLE, array=INIT_VAL.
- Read latency: rdata is valid on the cycle after aen is first sampled low and holds until the next completed read.
- Program commit: the array bit is visible to a read starting the cycle after aen is first sampled low.
- Setup: mode must be sampled high at least 1 cycle before aen rises. Mode and aen rising on the same edge is an err[1].
- Back-to-back pulses: aen may rise again the cycle after it falls while the mode is held.
- rst asserted mid-pulse aborts the pulse, performs no commit, and reloads INIT_VAL.
- err_o bits are set on the cycle after the violating sample.

## Structure
- Package efuse_pkg:
  - state enum efuse_emu_st_e.
  - err bit index constants ERR_MODE/ERR_SETUP/ERR_SHORT/ERR_ABORT.
  - shared localparam EFUSE_AW=8.
- Sub-module efuse_emu_array: NBYTE x 8 storage with a single-bit set port and a byte read port, synchronous reset to INIT_VAL.
- Top level holds the FSM, the width counter, the address capture and the error/count logic.

## Test plan
- Reset, rden=1, one cycle later aen=1 for 2 cycles at addr 0x08 -> rdata=INIT_VAL byte 1 on the cycle after aen falls; err=0.
- pgmen, aen for 4 cycles at addr 0x0B, then read at addr 0x08 -> rdata bit3=1; pgm_cnt=1.
- Program pulse 3 cycles at addr 0x00 -> no blow, err[2]=1. Read at addr 0x00 -> 8'h00. err_clr -> err=0.
- pgmen and rden both high -> err[0]=1, FSM in IDLE, subsequent aen ignored until a mode is re-armed.
- addr changes 0x10->0x11 during a program pulse -> err[3]=1, no bit blown. rst mid-pulse -> array=INIT_VAL, outputs 0.
- aen rising together with rden -> err[1]=1, rdata unchanged.
